// File: rtl/stopwatch_digit_source.sv
// MM:SS stopwatch feeding the 4-digit display multiplexer: debounced start/stop
// and clear buttons drive an IDLE/RUN/PAUSE FSM that gates a BCD seconds counter.

module stopwatch_debounce #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic evt
);
  localparam int DBW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [DBW-1:0] DB_LAST = DBW'(DB_CYCLES - 1);

  logic           s1, s2, level, level_q;
  logic [DBW-1:0] cnt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      cnt     <= '0;
    end else begin
      s1      <= raw;
      s2      <= s1;
      level_q <= level;
      // any return to the accepted level restarts the stability window
      if (s2 == level) begin
        cnt <= '0;
      end else if (cnt == DB_LAST) begin
        level <= s2;
        cnt   <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  assign evt = level & ~level_q;
endmodule

module stopwatch_digit_source #(
  parameter int CLKS_PER_TICK = 100_000_000,
  parameter int DB_CYCLES     = 1_000_000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_start_stop,
  input  logic        btn_clear,
  output logic [15:0] digits,
  output logic        running,
  output logic        wrap
);
  localparam int PW = $clog2(CLKS_PER_TICK);
  localparam logic [PW-1:0] PLAST = PW'(CLKS_PER_TICK - 1);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

  state_t        state, state_nxt;
  logic [1:0]    raw, evt;
  logic          ss_evt, clr_evt, tick;
  logic [PW-1:0] presc;
  logic [15:0]   digits_inc;

  assign raw = {btn_clear, btn_start_stop};

  for (genvar i = 0; i < 2; i++) begin : g_btn
    stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_db (
      .clk  (clk),
      .reset(reset),
      .raw  (raw[i]),
      .evt  (evt[i])
    );
  end

  assign ss_evt  = evt[0];
  assign clr_evt = evt[1];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (clr_evt) begin
      state_nxt = IDLE;
    end else if (ss_evt) begin
      case (state)
        IDLE:    state_nxt = RUN;
        RUN:     state_nxt = PAUSE;
        PAUSE:   state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign running = (state == RUN);
  assign tick    = running && (presc == PLAST);

  // BCD cascade: ss 00-59, mm 00-59, rolling 59:59 over to 00:00
  always_comb begin
    digits_inc = digits;
    if (digits[3:0] != 4'd9) begin
      digits_inc[3:0] = digits[3:0] + 4'd1;
    end else begin
      digits_inc[3:0] = 4'd0;
      if (digits[7:4] != 4'd5) begin
        digits_inc[7:4] = digits[7:4] + 4'd1;
      end else begin
        digits_inc[7:4] = 4'd0;
        if (digits[11:8] != 4'd9) begin
          digits_inc[11:8] = digits[11:8] + 4'd1;
        end else begin
          digits_inc[11:8] = 4'd0;
          if (digits[15:12] != 4'd5) digits_inc[15:12] = digits[15:12] + 4'd1;
          else                       digits_inc[15:12] = 4'd0;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      presc  <= '0;
      digits <= 16'h0000;
      wrap   <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (clr_evt || state == IDLE) begin
        presc <= '0;
        if (clr_evt) digits <= 16'h0000;
      end else if (tick) begin
        presc  <= '0;
        digits <= digits_inc;
        wrap   <= (digits == 16'h5959);
      end else if (running) begin
        presc <= presc + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_stopwatch_digit_source.sv
// Scoreboard bench: expected digit values are queued as buttons are pressed and
// popped whenever the displayed word changes; timing points checked directly.

module tb_stopwatch_digit_source;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        btn_start_stop = 1'b0;
  logic        btn_clear = 1'b0;
  logic [15:0] digits;
  logic        running, wrap;

  int          n_chk = 0;
  int          n_err = 0;
  int          wrap_cnt = 0;
  int          wait_cnt;
  logic [15:0] exp_q[$];
  logic [15:0] prev_dig = 16'h0000;

  stopwatch_digit_source #(.CLKS_PER_TICK(4), .DB_CYCLES(2)) dut (
    .clk           (clk),
    .reset         (reset),
    .btn_start_stop(btn_start_stop),
    .btn_clear     (btn_clear),
    .digits        (digits),
    .running       (running),
    .wrap          (wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [15:0] bcd(input int n);
    int m, s;
    m = (n % 3600) / 60;
    s = n % 60;
    return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10)};
  endfunction

  always @(posedge clk) begin
    #1;
    if (digits !== prev_dig) begin
      if (exp_q.size() == 0) chk("dig_unexp", {16'h0, digits}, {16'h0, prev_dig});
      else                   chk("dig_seq", {16'h0, digits}, {16'h0, exp_q.pop_front()});
      prev_dig = digits;
    end
    if (wrap === 1'b1) wrap_cnt++;
  end

  initial begin
    // reset phase
    #40;
    chk("rst_dig", {16'h0, digits}, 32'h0);
    chk("rst_run", {31'h0, running}, 32'h0);
    chk("rst_wrap", {31'h0, wrap}, 32'h0);
    reset = 1'b0;
    step(3);
    chk("post_rst_dig", {16'h0, digits}, 32'h0);
    chk("post_rst_run", {31'h0, running}, 32'h0);

    // single-cycle glitch must be rejected
    btn_start_stop = 1'b1;
    step(1);
    btn_start_stop = 1'b0;
    step(10);
    chk("glitch_run", {31'h0, running}, 32'h0);
    chk("glitch_dig", {16'h0, digits}, 32'h0);

    // start: running 5 edges after first sample, first tick 4 edges later
    for (int n = 1; n <= 10; n++) exp_q.push_back(bcd(n));
    btn_start_stop = 1'b1;
    step(4);
    chk("start_run_early", {31'h0, running}, 32'h0);
    step(1);
    chk("start_run", {31'h0, running}, 32'h1);
    step(3);
    chk("first_tick_early", {16'h0, digits}, 32'h0);
    step(1);
    chk("first_tick", {16'h0, digits}, 32'h0001);
    step(1);
    btn_start_stop = 1'b0;
    step(34);
    chk("dig_0009", {16'h0, digits}, 32'h0009);
    step(1);
    chk("dig_0010", {16'h0, digits}, 32'h0010);

    // clear while running
    exp_q.push_back(bcd(11));
    exp_q.push_back(16'h0000);
    btn_clear = 1'b1;
    step(4);
    chk("pre_clr_dig", {16'h0, digits}, 32'h0011);
    step(1);
    chk("clr_dig", {16'h0, digits}, 32'h0);
    chk("clr_run", {31'h0, running}, 32'h0);
    btn_clear = 1'b0;
    step(8);

    // pause at 0003 with prescaler mid-count, then resume
    for (int n = 1; n <= 3; n++) exp_q.push_back(bcd(n));
    btn_start_stop = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    step(2);
    chk("run2", {31'h0, running}, 32'h1);
    step(10);
    chk("run2_dig", {16'h0, digits}, 32'h0002);
    btn_start_stop = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    step(1);
    chk("pause_early", {31'h0, running}, 32'h1);
    step(1);
    chk("pause_run", {31'h0, running}, 32'h0);
    chk("pause_dig", {16'h0, digits}, 32'h0003);
    step(20);
    chk("pause_hold_dig", {16'h0, digits}, 32'h0003);
    chk("pause_hold_run", {31'h0, running}, 32'h0);
    exp_q.push_back(bcd(4));
    btn_start_stop = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    step(1);
    chk("resume_early", {31'h0, running}, 32'h0);
    step(1);
    chk("resume_run", {31'h0, running}, 32'h1);
    chk("resume_dig", {16'h0, digits}, 32'h0003);
    step(1);
    chk("resume_tick", {16'h0, digits}, 32'h0004);

    // run on to 59:59 and through the wrap
    for (int n = 5; n <= 3600; n++) exp_q.push_back(bcd(n));
    wait_cnt = 0;
    while (digits !== 16'h5959 && wait_cnt < 20000) begin
      step(1);
      wait_cnt++;
    end
    chk("reach_5959_cycles", wait_cnt, 14380);
    step(3);
    chk("hold_5959", {16'h0, digits}, 32'h5959);
    chk("wrap_early", {31'h0, wrap}, 32'h0);
    step(1);
    chk("wrap_dig", {16'h0, digits}, 32'h0);
    chk("wrap_pulse", {31'h0, wrap}, 32'h1);
    chk("wrap_run", {31'h0, running}, 32'h1);
    step(1);
    chk("wrap_end", {31'h0, wrap}, 32'h0);
    chk("wrap_still_run", {31'h0, running}, 32'h1);

    // both buttons together: clear wins
    exp_q.push_back(bcd(1));
    exp_q.push_back(16'h0000);
    btn_start_stop = 1'b1;
    btn_clear = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    btn_clear = 1'b0;
    step(2);
    chk("both_run", {31'h0, running}, 32'h0);
    chk("both_dig", {16'h0, digits}, 32'h0);
    step(8);
    chk("both_stay_idle", {31'h0, running}, 32'h0);

    // async reset mid-run
    for (int n = 1; n <= 3; n++) exp_q.push_back(bcd(n));
    exp_q.push_back(16'h0000);
    btn_start_stop = 1'b1;
    step(3);
    btn_start_stop = 1'b0;
    step(2);
    chk("run3", {31'h0, running}, 32'h1);
    step(13);
    chk("run3_dig", {16'h0, digits}, 32'h0003);
    #3 reset = 1'b1;
    #1;
    chk("async_dig", {16'h0, digits}, 32'h0);
    chk("async_run", {31'h0, running}, 32'h0);
    chk("async_wrap", {31'h0, wrap}, 32'h0);
    #10 reset = 1'b0;
    step(3);
    chk("after_async_dig", {16'h0, digits}, 32'h0);
    chk("after_async_run", {31'h0, running}, 32'h0);

    chk("queue_drained", exp_q.size(), 0);
    chk("wrap_count", wrap_cnt, 1);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
